// File: rtl/bram_bank_reader.sv
// Sequential reader for the 3-lane coefficient bank, presented as a valid/ready stream with lane order restored.
// Latency: first word valid two edges after start is sampled, then 1 word/cycle; done one cycle after the last handshake.
// Backpressure: reads are issued only against free buffer credit, so a stalled stream holds 2 words and has none in flight.
module bbr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      occ <= occ + CW'(1);
            else if (pop && !push) occ <= occ - CW'(1);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module bram_bank_reader #(
    parameter int DATA_WIDTH = 54,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bank_addr_read,
    input  logic [DATA_WIDTH-1:0] bank_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
    localparam int LANE = DATA_WIDTH / 3;
    localparam int RW   = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [RW-1:0]         remaining;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            occ;
    logic [2:0]            credit_used;
    logic                  issue_en;
    logic                  final_issue;
    logic                  pop;
    entry_t                push_entry;
    entry_t                head_entry;

    // A word still in the bank pipeline already owns a buffer slot.
    assign pop            = m_valid && m_ready;
    assign credit_used    = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue_en       = (state == READ) && (remaining != '0) && (credit_used < 3'd2);
    assign final_issue    = issue_en && (remaining == RW'(1));
    assign bank_addr_read = issue_en ? addr : addr_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length != '0) ? READ : DONE;
            READ:    if ((remaining == '0) || final_issue) state_nxt = DRAIN;
            DRAIN:   if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            addr_hold     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            addr_hold     <= bank_addr_read;
            inflight      <= issue_en;
            inflight_last <= final_issue;
            if ((state == IDLE) && start) begin
                addr      <= base_addr;
                remaining <= length;
            end else if (issue_en) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - RW'(1);
            end
        end
    end

    // The bank returns lane 0 in its top bits; swap so lane 0 lands at the bottom.
    always_comb begin
        push_entry      = '0;
        push_entry.last = inflight_last;
        push_entry.dat  = {bank_data_out[LANE-1:0],
                           bank_data_out[2*LANE-1:LANE],
                           bank_data_out[3*LANE-1:2*LANE]};
    end

    bbr_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (2)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .occ      (occ)
    );

    assign m_valid = (occ != 2'd0);
    assign m_data  = head_entry.dat;
    assign m_last  = m_valid && head_entry.last;
endmodule

// File: tb/tb_bram_bank_reader.sv
// Bench for bram_bank_reader: random bank contents and backpressure, checked against an expected-word queue.
module tb_bram_bank_reader;
    localparam int DW    = 54;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] bank_addr_read;
    logic [DW-1:0] bank_data_out;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    logic [DW-1:0] bank_mem [DEPTH];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // One-cycle synchronous read, like the real BRAM bank.
    always @(posedge clk) bank_data_out <= bank_mem[bank_addr_read];

    bram_bank_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .bank_addr_read (bank_addr_read),
        .bank_data_out  (bank_data_out),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] restore_lanes(input logic [DW-1:0] w);
        return {w[17:0], w[35:18], w[53:36]};
    endfunction

    // Runs one burst; cycle n is the cycle after the n-th edge following the edge that sampled start.
    task automatic run_burst(input int base, input int len, input bit bp, input bit start_in_done,
                             output logic [DW-1:0] first_word);
        logic [DW:0]   exp_q[$];
        logic [DW:0]   e;
        logic [DW-1:0] prev_dat;
        logic          prev_last;
        bit            prev_stall = 1'b0;
        bit            saw_valid  = 1'b0;
        int            n_out = 0, n_last = 0, stall = 0;
        int            first_hs = -1, last_hs = -1, done_cyc = -1;
        first_word = '0;
        prev_dat   = '0;
        prev_last  = 1'b0;
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), restore_lanes(bank_mem[(base + i) % DEPTH])});

        @(posedge clk); #1;
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        start     = 1'b1;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int cyc = 1; (cyc < len * 10 + 60) && (done_cyc < 0); cyc++) begin
            if (bp) begin
                if (stall > 0) begin
                    m_ready = 1'b0;
                    stall--;
                end else if ($urandom_range(7) == 0) begin
                    m_ready = 1'b0;
                    stall   = 4;
                end else begin
                    m_ready = 1'($urandom_range(1));
                end
            end else begin
                m_ready = 1'b1;
            end
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_dat);
                check("stall_last", m_last, prev_last);
            end
            if (m_valid) saw_valid = 1'b1;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", n_out + 1, len);
                end else begin
                    e = exp_q.pop_front();
                    check("data", m_data, e[DW-1:0]);
                    check("last", m_last, e[DW]);
                end
                if (n_out == 0) begin
                    first_hs   = cyc;
                    first_word = m_data;
                end
                last_hs = cyc;
                n_out++;
                if (m_last) n_last++;
            end
            prev_stall = m_valid && !m_ready;
            prev_dat   = m_data;
            prev_last  = m_last;
            if (done) begin
                done_cyc = cyc;
                if (start_in_done) begin
                    start     = 1'b1;
                    length    = (AW + 1)'(3);
                    base_addr = '0;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;

        check("done_seen", (done_cyc >= 0), 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("word_count", n_out, len);
        check("last_count", n_last, (len > 0) ? 1 : 0);
        if (len == 0) begin
            check("len0_no_valid", saw_valid, 0);
            check("len0_done_cycle", done_cyc, 1);
        end else begin
            check("addr_hold", bank_addr_read, (base + len - 1) % DEPTH);
            if (!bp) begin
                check("first_hs_cycle", first_hs, 3);
                check("last_hs_cycle", last_hs, len + 2);
            end
            check("done_after_last", done_cyc, last_hs + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] fw;
        bit            done_seen;
        int            b;
        int            l;

        for (int i = 0; i < DEPTH; i++) bank_mem[i] = DW'({$urandom(), $urandom()});
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_addr", bank_addr_read, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_burst(0, 4, 1'b0, 1'b0, fw);

        bank_mem[5] = {18'h3_0000, 18'h2_0000, 18'h1_0000};
        run_burst(5, 1, 1'b0, 1'b0, fw);
        check("lane_order", fw, {18'h1_0000, 18'h2_0000, 18'h3_0000});

        run_burst(1022, 4, 1'b0, 1'b0, fw);

        for (int k = 0; k < 4; k++) run_burst($urandom_range(DEPTH - 1), 8, 1'b1, 1'b0, fw);

        run_burst(0, 0, 1'b0, 1'b1, fw);
        run_burst(17, 3, 1'b0, 1'b1, fw);

        run_burst($urandom_range(DEPTH - 1), DEPTH, 1'b0, 1'b0, fw);

        // Fill the buffer under stall, then reset mid-burst.
        @(posedge clk); #1;
        base_addr = AW'(100);
        length    = (AW + 1)'(8);
        start     = 1'b1;
        m_ready   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("full_valid", m_valid, 1);
        check("stall_no_issue", bank_addr_read, 101);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_idle_valid", m_valid, 0);

        run_burst(7, 5, 1'b0, 1'b0, fw);

        for (int k = 0; k < 6; k++) begin
            b = $urandom_range(DEPTH - 1);
            l = $urandom_range(40, 1);
            run_burst(b, l, 1'($urandom_range(1)), 1'b0, fw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bram_bank_reader.md
# bram_bank_reader

Streaming read sequencer that sits directly downstream of the three-BRAM18 coefficient bank. It issues sequential read addresses into the bank and absorbs the bank's one-cycle synchronous read latency. It restores lane order and presents the coefficients as a valid/ready stream to the next DFT stage. A 2-entry output buffer with credit accounting gives full throughput without ever dropping a word under backpressure.

## Interface
Parameters:
- DATA_WIDTH, 54, coefficient width; three 18-bit lanes.
- ADDR_WIDTH, 10, bank address width; depth 2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; sampled only when busy=0.
- base_addr  input  ADDR_WIDTH  first bank address of the burst.
- length  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse at burst end.
- bank_addr_read  output  ADDR_WIDTH  drives the bank's addr_read.
- bank_data_out  input  DATA_WIDTH  bank's data_out; valid one cycle after an address is presented.
- m_data  output  DATA_WIDTH  stream data, lane-restored.
- m_valid  output  1  stream valid.
- m_ready  input  1  downstream ready.
- m_last  output  1  high with the final word of the burst.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start with length≠0, latch base_addr and length, then go to READ. On start with length=0, go to DONE with no output.
  - READ: issue reads until the remaining-to-issue count reaches 0, then go to DRAIN.
  - DRAIN: wait until inflight=0 and the buffer is empty after the final handshake, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- busy=1 in READ, DRAIN and DONE. start is ignored while busy.
- Issue rule: issue_en = READ && remaining≠0 && (occ + inflight − pop) < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: 1 if a read was issued last cycle.
  - pop: m_valid && m_ready.
- On issue: bank_addr_read = current address. The address increments modulo 2^ADDR_WIDTH and remaining decrements.
  - Wrap example: 1023 → 0 for ADDR_WIDTH=10.
- When not issuing, bank_addr_read holds its last value.
- On the cycle after an issue, bank_data_out is written into the buffer tail with lane reordering: m_data = {bank_data_out[17:0], bank_data_out[35:18], bank_data_out[53:36]}. The bank returns lane 0 in its top 18 bits; this swap undoes that.
- The buffer is a 2-entry FIFO; its head drives m_data and m_valid = (occ≠0).
  - Push and pop in the same cycle are allowed; occ is then unchanged.
  - The credit rule guarantees a push never finds occ=2 without a simultaneous pop. The buffer never overflows.
- m_last is tagged at push time on the word whose issue took remaining from 1 to 0. It travels with the entry.
- AXI-stream rule: once m_valid=1, m_data and m_last stay stable until the handshake.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, bank_addr_read=0, FSM=IDLE, occ=0, inflight=0.
- Reset mid-burst immediately discards buffered and inflight words. No done pulse is produced.
- First-word latency:
  - Edge E0 samples start.
  - First address is driven after E0 and registered by the bank at E1.
  - The word enters the buffer at E2; m_valid=1 after E2.
- Throughput with m_ready held high is 1 word/cycle (steady state occ=1, inflight=1).
  - An N-word burst's last handshake occurs N+1 cycles after E0.
  - done pulses the cycle after the final handshake.
- Under backpressure, at most 2 words are held plus 0 inflight. Issue resumes the cycle pop returns.
- A start asserted the same cycle done is high is ignored. It is accepted in IDLE the next cycle.

## Test plan
- Reset, then a burst with base=0, length=4, m_ready=1 → addresses 0,1,2,3 issued on consecutive cycles; 4 words out on consecutive cycles with m_last on the 4th; done one cycle later; busy low after.
- Lane order: bank word for address 5 = {18'h3_0000, 18'h2_0000, 18'h1_0000} → m_data = {18'h1_0000, 18'h2_0000, 18'h3_0000}.
- Wrap: base=1022, length=4 → addresses 1022, 1023, 0, 1 in order; all 4 words delivered.
- Backpressure: length=8, m_ready toggled randomly, held low for 5-cycle stretches → occ never exceeds 2; m_data stable while stalled; all 8 words in order; exactly one m_last.
- Edge lengths: length=0 → done after start with no m_valid. length=1024 → all addresses issued exactly once.
- Reset asserted mid-burst with occ=2 → m_valid=0 immediately and no done pulse; a new burst then runs correctly.
